// File: rtl/clk_tick_pkg.sv
// Shared constants and channel state type for the clk200m tick generator.
// Every channel counts in DIV_W_MAX bits internally; narrower divide values are zero-extended.
package clk_tick_pkg;

    localparam int N_CH_MAX  = 16;
    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 32;
    localparam int DIV_W_MAX = 32;
    localparam int CH_IDX_W  = $clog2(N_CH_MAX);

    typedef struct packed {
        logic [DIV_W_MAX-1:0] cnt;
        logic                 tick;
        logic                 sq;
    } chan_state_t;

endpackage

// File: rtl/clk_tick_chan.sv
// One programmable divider channel: stores its divide value, counts down, and emits tick and sq.
// reload_i already carries the write-through value, so div_q simply follows it every cycle.
module clk_tick_chan
    import clk_tick_pkg::*;
#(
    parameter int               DIV_W       = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic [DIV_W-1:0] reload_i,
    output logic [DIV_W-1:0] div_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     div_d;
    chan_state_t          state_q;
    chan_state_t          state_d;
    logic [DIV_W_MAX-1:0] reload_ext;

    assign reload_ext = DIV_W_MAX'(reload_i);
    assign div_d      = reload_i;

    // Sync beats enable; cnt==0 always reloads so cnt never wraps below zero.
    always_comb begin
        state_d = state_q;
        if (sync_i) begin
            state_d.cnt  = reload_ext;
            state_d.tick = 1'b0;
            state_d.sq   = 1'b0;
        end else if (!en_i) begin
            state_d.cnt  = reload_ext;
            state_d.tick = 1'b0;
        end else if (state_q.cnt == '0) begin
            state_d.cnt  = reload_ext;
            state_d.tick = 1'b1;
            state_d.sq   = ~state_q.sq;
        end else begin
            state_d.cnt  = state_q.cnt - DIV_W_MAX'(1);
            state_d.tick = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q         <= DEFAULT_DIV;
            state_q.cnt   <= DIV_W_MAX'(DEFAULT_DIV);
            state_q.tick  <= 1'b0;
            state_q.sq    <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
        end
    end

    assign div_o  = div_q;
    assign tick_o = state_q.tick;
    assign sq_o   = state_q.sq;

endmodule

// File: rtl/clk_tick_gen.sv
// Free-running clk200m counter plus N_CH programmable tick/square divider channels.
// Ticks are meant as clock enables; no clock is derived from any counter bit.
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int               N_CH        = 4,
    parameter int               DIV_W       = DIV_W_DEF,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
    input  logic                clk200m,
    input  logic                rst,
    output logic [CNT_W-1:0]    clkdiv,
    input  logic [N_CH-1:0]     en,
    input  logic                sync_all,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic                cfg_err,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     sq
);

    logic [CNT_W-1:0] clkdiv_q;
    logic [CNT_W-1:0] clkdiv_d;
    logic             cfg_err_q;
    logic             cfg_err_d;
    logic             ch_in_range;
    logic             cfg_valid;
    logic [N_CH-1:0]  chan_we;
    logic [DIV_W-1:0] div_w    [N_CH];
    logic [DIV_W-1:0] reload_w [N_CH];

    assign ch_in_range = int'({1'b0, cfg_ch}) < N_CH;
    assign cfg_valid   = cfg_we && ch_in_range;
    assign clkdiv_d    = clkdiv_q + CNT_W'(1);
    assign cfg_err_d   = cfg_we && !ch_in_range;

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            clkdiv_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            clkdiv_q  <= clkdiv_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // A write lands in the reload value the same cycle, so a disabled or wrapping channel uses it at once.
    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        localparam logic [CH_IDX_W-1:0] IDX = CH_IDX_W'(c);

        assign chan_we[c]  = cfg_valid && (cfg_ch == IDX);
        assign reload_w[c] = chan_we[c] ? cfg_div : div_w[c];

        clk_tick_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i    (clk200m),
            .rst_i    (rst),
            .en_i     (en[c]),
            .sync_i   (sync_all),
            .reload_i (reload_w[c]),
            .div_o    (div_w[c]),
            .tick_o   (tick[c]),
            .sq_o     (sq[c])
        );
    end

    assign clkdiv  = clkdiv_q;
    assign cfg_err = cfg_err_q;

endmodule
